// File: rtl/std_nbdcache_vd_pkg.sv
// Shared types and helpers for the D-cache valid/dirty store controller.
package std_nbdcache_vd_pkg;

  typedef enum logic [1:0] {INIT, IDLE, RMW} vd_state_e;

  localparam int unsigned VD_BITS_PER_WAY = 2;

  // Helpers work on a fixed wide word; callers zero-extend and truncate.
  localparam int unsigned VD_MAX_DATA_WIDTH = 128;

  typedef logic [VD_MAX_DATA_WIDTH-1:0] vd_word_t;

  function automatic vd_word_t vd_merge(input vd_word_t old_data, input vd_word_t new_data,
                                        input vd_word_t mask);
    return (old_data & ~mask) | (new_data & mask);
  endfunction

  // Padding bits are zero, so a partially used top byte with all real mask bits set reads as
  // non-aligned and safely takes the read-modify-write path.
  function automatic logic vd_is_byte_aligned(input vd_word_t mask, input int unsigned byte_width);
    logic aligned;
    aligned = 1'b1;
    for (int unsigned i = 0; i < VD_MAX_DATA_WIDTH; i++) begin
      if (mask[i] != mask[(i / byte_width) * byte_width]) aligned = 1'b0;
    end
    return aligned;
  endfunction

endpackage

// File: rtl/tc_sram_impl.sv
// Behavioural single-port SRAM macro with byte enables and one cycle read latency.
module tc_sram_impl #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned NumPorts  = 1,
  parameter int unsigned Latency   = 1,
  parameter string       SimInit   = "none",
  parameter type         impl_in_t  = logic,
  parameter type         impl_out_t = logic,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  impl_in_t                            impl_i,
  output impl_out_t                           impl_o,
  input  logic [NumPorts-1:0]                 req_i,
  input  logic [NumPorts-1:0]                 we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
  output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o
);

  if (NumPorts != 1 || Latency != 1) begin : gen_cfg_check
    $error("tc_sram_impl model supports only NumPorts = 1 and Latency = 1");
  end

  logic [DataWidth-1:0] mem_q [NumWords];
  logic [DataWidth-1:0] rdata_q;
  logic                 unused_impl;

  assign impl_o      = impl_out_t'('0);
  assign unused_impl = ^impl_i;
  assign rdata_o[0]  = rdata_q;

  always_ff @(posedge clk_i) begin
    if (req_i[0] && we_i[0]) begin
      for (int unsigned i = 0; i < DataWidth; i++) begin
        if (be_i[0][i / ByteWidth]) mem_q[addr_i[0]][i] <= wdata_i[0][i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= (SimInit == "ones") ? '1 : '0;
    end else if (req_i[0] && !we_i[0]) begin
      rdata_q <= mem_q[addr_i[0]];
    end
  end

endmodule

// File: rtl/std_nbdcache_vd_ctrl.sv
// Valid/dirty store controller: invalidate sweep, masked writes (RMW when not byte-aligned),
// grant/valid handshake. Define STD_NBDCACHE_VD_STATS_EN to add the rmw_cnt_o counter.
module std_nbdcache_vd_ctrl
  import std_nbdcache_vd_pkg::*;
#(
  parameter int unsigned NumWords   = 256,
  parameter int unsigned NumWays    = 8,
  parameter int unsigned ByteWidth  = 8,
  parameter string       SimInit    = "none",
  parameter type         impl_in_t  = logic,
  parameter type         impl_out_t = logic,
  localparam int unsigned DataWidth = VD_BITS_PER_WAY * NumWays,
  localparam int unsigned AddrWidth = $clog2(NumWords),
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  impl_in_t             impl_i,
  output impl_out_t            impl_o,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [DataWidth-1:0] bmask_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  input  logic                 flush_req_i,
  output logic                 busy_o,
  output logic                 flush_done_o
`ifdef STD_NBDCACHE_VD_STATS_EN
  ,
  output logic [31:0]          rmw_cnt_o
`endif
);

  if (NumWords < 2 || DataWidth > VD_MAX_DATA_WIDTH) begin : gen_cfg_check
    $error("std_nbdcache_vd_ctrl: NumWords must be >= 2 and 2*NumWays <= 128");
  end

  vd_state_e            state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [DataWidth-1:0] bmask_q, bmask_d;
  logic                 flush_pending_q, flush_pending_d;
  logic                 busy_q, busy_d;
  logic                 rvalid_q, rvalid_d;
  logic                 flush_done_q, flush_done_d;

  logic                 gnt;
  logic                 flush_now;
  logic                 mask_aligned;
  logic [BeWidth-1:0]   be_direct;
  logic [DataWidth-1:0] merged;

  logic                 sram_req;
  logic                 sram_we;
  logic [AddrWidth-1:0] sram_addr;
  logic [DataWidth-1:0] sram_wdata;
  logic [BeWidth-1:0]   sram_be;
  logic [DataWidth-1:0] sram_rdata;

  assign flush_now    = flush_req_i | flush_pending_q;
  assign mask_aligned = vd_is_byte_aligned(vd_word_t'(bmask_i), ByteWidth);
  assign merged       = DataWidth'(vd_merge(vd_word_t'(sram_rdata), vd_word_t'(wdata_q),
                                            vd_word_t'(bmask_q)));

  always_comb begin
    be_direct = '1;
    for (int unsigned i = 0; i < DataWidth; i++) begin
      if (!bmask_i[i]) be_direct[i / ByteWidth] = 1'b0;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    bmask_d         = bmask_q;
    flush_pending_d = flush_pending_q;
    rvalid_d        = 1'b0;
    flush_done_d    = 1'b0;
    gnt             = 1'b0;
    sram_req        = 1'b0;
    sram_we         = 1'b0;
    sram_addr       = addr_i;
    sram_wdata      = wdata_i;
    sram_be         = '1;

    unique case (state_q)
      INIT: begin
        sram_req   = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = cnt_q;
        sram_wdata = '0;
        cnt_d      = cnt_q + AddrWidth'(1);
        if (cnt_q == AddrWidth'(NumWords - 1)) begin
          state_d      = IDLE;
          cnt_d        = '0;
          flush_done_d = 1'b1;
        end
      end
      IDLE: begin
        if (flush_now) begin
          state_d         = INIT;
          cnt_d           = '0;
          flush_pending_d = 1'b0;
        end else if (req_i) begin
          gnt      = 1'b1;
          sram_req = 1'b1;
          if (!we_i) begin
            rvalid_d = 1'b1;
          end else if (mask_aligned) begin
            sram_we = 1'b1;
            sram_be = be_direct;
          end else begin
            // Read the old word now; the merged write goes out from RMW next cycle.
            addr_d  = addr_i;
            wdata_d = wdata_i;
            bmask_d = bmask_i;
            state_d = RMW;
          end
        end
      end
      RMW: begin
        sram_req   = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = addr_q;
        sram_wdata = merged;
        if (flush_req_i) flush_pending_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase

    busy_d = (state_d == INIT);

    // Reset suppresses any SRAM access, dropping an in-flight RMW write.
    if (!rst_ni) begin
      sram_req = 1'b0;
      gnt      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= INIT;
      cnt_q           <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      bmask_q         <= '0;
      flush_pending_q <= 1'b0;
      busy_q          <= 1'b1;
      rvalid_q        <= 1'b0;
      flush_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      bmask_q         <= bmask_d;
      flush_pending_q <= flush_pending_d;
      busy_q          <= busy_d;
      rvalid_q        <= rvalid_d;
      flush_done_q    <= flush_done_d;
    end
  end

  assign gnt_o        = gnt;
  assign rvalid_o     = rvalid_q;
  assign rdata_o      = sram_rdata;
  assign busy_o       = busy_q;
  assign flush_done_o = flush_done_q;

`ifdef STD_NBDCACHE_VD_STATS_EN
  logic [31:0] rmw_cnt_q, rmw_cnt_d;

  always_comb begin
    rmw_cnt_d = rmw_cnt_q;
    if (state_q == IDLE && state_d == RMW && rmw_cnt_q != '1) rmw_cnt_d = rmw_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) rmw_cnt_q <= '0;
    else         rmw_cnt_q <= rmw_cnt_d;
  end

  assign rmw_cnt_o = rmw_cnt_q;
`endif

  tc_sram_impl #(
    .NumWords   (NumWords),
    .DataWidth  (DataWidth),
    .ByteWidth  (ByteWidth),
    .NumPorts   (1),
    .Latency    (1),
    .SimInit    (SimInit),
    .impl_in_t  (impl_in_t),
    .impl_out_t (impl_out_t)
  ) valid_dirty_sram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .impl_i  (impl_i),
    .impl_o  (impl_o),
    .req_i   (sram_req),
    .we_i    (sram_we),
    .addr_i  (sram_addr),
    .wdata_i (sram_wdata),
    .be_i    (sram_be),
    .rdata_o (sram_rdata)
  );

endmodule
